// File: rtl/axi4_dma_read_if.sv
// AXI4 read-address / read-data channel bundle for the 512-bit DMA read master.
interface axi4_dma_read_if;
    logic         io_axi_arvalid;
    logic         io_axi_arready;
    logic [63:0]  io_axi_araddr;
    logic         io_axi_arid;
    logic [7:0]   io_axi_arlen;
    logic [2:0]   io_axi_arsize;
    logic [1:0]   io_axi_arburst;
    logic         io_axi_rvalid;
    logic         io_axi_rready;
    logic [511:0] io_axi_rdata;
    logic         io_axi_rid;
    logic [1:0]   io_axi_rresp;
    logic         io_axi_rlast;

    modport master (
        output io_axi_arvalid, io_axi_araddr, io_axi_arid, io_axi_arlen,
               io_axi_arsize, io_axi_arburst, io_axi_rready,
        input  io_axi_arready, io_axi_rvalid, io_axi_rdata, io_axi_rid,
               io_axi_rresp, io_axi_rlast
    );

    modport slave (
        input  io_axi_arvalid, io_axi_araddr, io_axi_arid, io_axi_arlen,
               io_axi_arsize, io_axi_arburst, io_axi_rready,
        output io_axi_arready, io_axi_rvalid, io_axi_rdata, io_axi_rid,
               io_axi_rresp, io_axi_rlast
    );
endinterface

// File: rtl/axi4_dma_read.sv
// AXI4 read-DMA master: issues num_burst INCR bursts and sinks the data, counting clocks and bad beats.
// Define AXI4_DMA_READ_CHECK_EN to also compare each beat against the beat-index data pattern.
module axi4_dma_read #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    axi4_dma_read_if.master        axi,
    input  logic [63:0]            io_start_addr,
    input  logic [7:0]             io_len_burst,
    input  logic [31:0]            io_num_burst,
    input  logic [7:0]             io_stride,
    output logic [31:0]            io_cnt_clk,
    output logic [31:0]            io_err_cnt,
    input  logic                   io_ap_start,
    output logic                   io_ap_ready,
    output logic                   io_ap_done,
    output logic                   io_ap_idle
);
    localparam int NUM_LANES = 16;
    localparam int VEC_W     = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [63:0] araddr_q;
    logic [63:0] step_q;
    logic [7:0]  len_q;
    logic [31:0] num_q;
    logic [31:0] issued;
    logic [31:0] completed;
    logic [31:0] beat_idx;
    logic [31:0] cnt_clk;
    logic [31:0] err_cnt;
    logic [8:0]  outstanding;
    logic        arvalid_q;
    logic        rready_q;
    logic        done_q;
    logic        idle_q;

    logic        ar_hs;
    logic        r_hs;
    logic        last_hs;
    logic        final_beat;
    logic        beat_err;
    logic [31:0] issued_n;
    logic [8:0]  outstanding_n;

    // rready/arvalid are only ever high in RUN, so the handshakes imply RUN.
    assign ar_hs      = arvalid_q & axi.io_axi_arready;
    assign r_hs       = rready_q & axi.io_axi_rvalid;
    assign last_hs    = r_hs & axi.io_axi_rlast;
    assign final_beat = last_hs && ((completed + 32'd1) == num_q);
    assign issued_n   = issued + {31'd0, ar_hs};

    always_comb begin
        outstanding_n = outstanding;
        if (ar_hs && !last_hs)
            outstanding_n = outstanding + 9'd1;
        else if (!ar_hs && last_hs)
            outstanding_n = outstanding - 9'd1;
    end

`ifdef AXI4_DMA_READ_CHECK_EN
    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [NUM_LANES-1:0]            lane_bad;
    logic                            unused;

    assign lanes  = axi.io_axi_rdata;
    assign unused = axi.io_axi_rid;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_bad[g] = (lanes[g] != beat_idx);
    end

    // A beat with both a bad response and bad data still counts once.
    assign beat_err = (axi.io_axi_rresp != 2'b00) || (|lane_bad);
`else
    logic unused;
    assign unused   = ^{axi.io_axi_rid, axi.io_axi_rdata, NUM_LANES[0], VEC_W[0]};
    assign beat_err = (axi.io_axi_rresp != 2'b00);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            araddr_q    <= '0;
            step_q      <= '0;
            len_q       <= '0;
            num_q       <= '0;
            issued      <= '0;
            completed   <= '0;
            beat_idx    <= '0;
            cnt_clk     <= '0;
            err_cnt     <= '0;
            outstanding <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_ap_start) begin
                        araddr_q    <= io_start_addr;
                        step_q      <= {50'd0, io_stride, 6'd0};
                        len_q       <= io_len_burst;
                        num_q       <= io_num_burst;
                        issued      <= '0;
                        completed   <= '0;
                        beat_idx    <= '0;
                        cnt_clk     <= '0;
                        err_cnt     <= '0;
                        outstanding <= '0;
                        arvalid_q   <= (io_num_burst != 32'd0);
                        rready_q    <= 1'b1;
                        idle_q      <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_clk     <= cnt_clk + 32'd1;
                    issued      <= issued_n;
                    outstanding <= outstanding_n;
                    if (ar_hs)
                        araddr_q <= araddr_q + step_q;
                    if (last_hs)
                        completed <= completed + 32'd1;
                    if (r_hs) begin
                        beat_idx <= beat_idx + 32'd1;
                        if (beat_err && (err_cnt != '1))
                            err_cnt <= err_cnt + 32'd1;
                    end
                    if ((num_q == 32'd0) || final_beat) begin
                        state     <= S_DONE;
                        done_q    <= 1'b1;
                        rready_q  <= 1'b0;
                        arvalid_q <= 1'b0;
                    end else begin
                        // A pending request can only see outstanding drop, so it is never withdrawn.
                        arvalid_q <= (issued_n < num_q) &&
                                     (outstanding_n < 9'(MAX_OUTSTANDING));
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    idle_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign axi.io_axi_arvalid = arvalid_q;
    assign axi.io_axi_araddr  = araddr_q;
    assign axi.io_axi_arid    = 1'b0;
    assign axi.io_axi_arlen   = len_q;
    assign axi.io_axi_arsize  = 3'd6;
    assign axi.io_axi_arburst = 2'b01;
    assign axi.io_axi_rready  = rready_q;

    assign io_cnt_clk  = cnt_clk;
    assign io_err_cnt  = err_cnt;
    assign io_ap_done  = done_q;
    assign io_ap_ready = done_q;
    assign io_ap_idle  = idle_q;
endmodule
